mu0_fetch_unit: RTL and testbench
=================================

# mu0_fetch_unit

Instruction fetch stage directly upstream of the MU0 control state machine (FETCH/EXEC1/EXEC2). Owns the PC, a one-entry prefetch buffer and the instruction register (IR). It supplies the decoded `extra` flag and a `stall` hold to the state register. When pipelining is enabled, it prefetches the next word from the shared memory port during EXEC cycles.

## Interface
- `ADDR_W`, 12: memory address width / PC width.
- `DATA_W`, 16: instruction width; opcode = `ir[DATA_W-1:DATA_W-4]`.
- `PC_RESET`, 0: PC value after reset.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch`  in  1  state machine is in FETCH.
- `exec1`  in  1  state machine is in EXEC1; qualifies `jump`.
- `pipeline_enabled`  in  1  allow prefetch outside FETCH.
- `jump`  in  1  taken branch this cycle; valid only with `exec1`.
- `jump_addr`  in  ADDR_W  branch target.
- `mem_grant`  in  1  memory port free for instruction fetch.
- `mem_ack`  in  1  read data valid for the outstanding request.
- `mem_rdata`  in  DATA_W  read data.
- `mem_req`  out  1  registered fetch request.
- `mem_addr`  out  ADDR_W  fetch address, equal to PC while `mem_req` is high.
- `ir`  out  DATA_W  instruction register.
- `extra`  out  1  IR holds LDA/STO/ADD/SUB (opcode 0–3) and IR is loaded.
- `stall`  out  1  hold the state register; combinational.
- `halted`  out  1  STP (opcode 7) taken; sticky until reset.
- `pc`  out  ADDR_W  next fetch address.

## Operation
- Storage: `pc`, `buf_data`/`buf_valid`, `ir`/`ir_loaded`, `outstanding`, `stale`, `halted`.
- **Request issue.** `mem_req` rises on the next edge when all of these hold:
  - `!outstanding`, `!buf_valid`, `mem_grant`, `!halted`;
  - `pipeline_enabled | fetch`.
- **Request hold.** `mem_req` stays high until `mem_ack` is sampled. It drops on that edge, and `outstanding` clears.
- **Ack, not stale.** Sets `buf_data <= mem_rdata`, `buf_valid <= 1`, and `pc <= pc + 1`. The PC is modulo 2^ADDR_W, so 0xFFF wraps to 0x000.
- **Ack, stale.** Data is discarded, PC is unchanged and `stale` clears.
- **Take.** When `fetch & buf_valid & !halted`:
  - `ir <= buf_data`, `ir_loaded <= 1`, `buf_valid <= 0`;
  - if the taken opcode is 7, set `halted <= 1`.
- **No bypass.** Ack data always lands in the buffer first. An ack during FETCH is taken on the following cycle.
- **Stall.** `stall = fetch & (!buf_valid | halted)`.
- **Jump.** When `jump & exec1`:
  - `pc <= jump_addr` and `buf_valid <= 0`;
  - if `outstanding` and the ack is not sampled this same cycle, set `stale <= 1`;
  - if the ack arrives in the same cycle as the jump, the jump wins: data is dropped and the PC takes `jump_addr`.
- **After a jump.** A new request is issued only after `stale` clears.
- **Halted.** No new requests are issued. An outstanding request still completes and fills the buffer, but the buffer is never taken.
- **Mid-request reset.** Reset asserted during a request clears everything immediately. A late `mem_ack` after reset is ignored because `outstanding` = 0.

## Timing
- **Reset values:** `mem_req`=0, `mem_addr`=`PC_RESET`, `ir`=0, `extra`=0, `stall`=`fetch`, `halted`=0, `pc`=`PC_RESET`; internal flags 0.
- **First request:** with `mem_grant` high, `mem_req` is high in cycle 1, i.e. after the first edge with `rst_n` high.
- **Minimum fetch latency:**
  - request high in cycle N, ack in cycle N;
  - buffer valid in cycle N+1, IR loaded at the end of N+1;
  - `extra` valid in N+2 (EXEC1).
- **Pipelined:** the next word is fetched during EXEC1/EXEC2. A following FETCH with a full buffer produces no stall.
- **Non-pipelined:** requests start only in FETCH, so every FETCH stalls for at least 1 cycle.
- `mem_addr`/`mem_req` are registered. `stall` and `extra` are combinational from registers and `fetch`.

## Test plan
- **Reset and first fetch.** Reset, `PC_RESET`=0, memory[0]=0x2005, zero-wait ack, `fetch` held.
  - `mem_req` is high at cycle 1 with addr 0.
  - `stall` is high in cycle 1; `ir`=0x2005 after cycle 2.
  - `extra`=1; `pc`=1.
- **Pipelined prefetch.** `pipeline_enabled`=1, 3-cycle memory latency, FETCH/EXEC1/EXEC2 sequence.
  - The second word is requested during EXEC1.
  - The next FETCH has `stall`=0.
- **Jump with outstanding request.** `jump` to 0x040 while a fetch of 0x003 is outstanding.
  - The 0x003 data is discarded.
  - The next `mem_addr` is 0x040; `pc` is 0x041 after its ack.
- **PC wrap.** `pc`=0xFFF, ack.
  - `pc`=0x000 and the next request uses addr 0x000.
- **STP.** Take 0x7000.
  - `halted`=1; `mem_req` is never raised again.
  - `stall`=1 on every later FETCH, until `rst_n`=0.
- **Reset mid-request.** Assert `rst_n`=0 while `mem_req`=1, then release; ack arrives 1 cycle after release.
  - The ack is ignored and `pc`=`PC_RESET`.
  - A fresh request to `PC_RESET` follows.

Source files
------------

// File: rtl/mu0_fetch_unit.sv
// mu0_fetch_unit: MU0 instruction fetch stage with PC, one-entry prefetch buffer and IR.
module mu0_fetch_unit #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch,
  input  logic              exec1,
  input  logic              pipeline_enabled,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              mem_grant,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] ir,
  output logic              extra,
  output logic              stall,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_buf_data, r_ir;
  logic              r_buf_valid, r_ir_loaded, r_req, r_stale, r_halted;
  logic              w_ack, w_fill, w_take, w_jmp, w_issue;
  assign w_ack   = r_req & mem_ack;
  assign w_fill  = w_ack & ~r_stale & ~w_jmp;
  assign w_take  = fetch & r_buf_valid & ~r_halted;
  assign w_jmp   = jump & exec1;
  // r_req doubles as the outstanding flag: it is high exactly while a read is in flight
  assign w_issue = ~r_req & ~r_buf_valid & mem_grant & ~r_halted & ~r_stale & (pipeline_enabled | fetch);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= PC_RESET;
      r_buf_data  <= '0;
      r_buf_valid <= 1'b0;
      r_ir        <= '0;
      r_ir_loaded <= 1'b0;
      r_req       <= 1'b0;
      r_stale     <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_req       <= w_issue | (r_req & ~mem_ack);
      r_stale     <= (w_jmp & r_req & ~mem_ack) ? 1'b1 : (w_ack ? 1'b0 : r_stale);
      r_pc        <= w_jmp ? jump_addr : (w_fill ? r_pc + 1'b1 : r_pc);
      r_buf_valid <= w_jmp ? 1'b0 : (w_fill ? 1'b1 : (w_take ? 1'b0 : r_buf_valid));
      if (w_fill) r_buf_data <= mem_rdata;
      if (w_take) begin
        r_ir        <= r_buf_data;
        r_ir_loaded <= 1'b1;
      end
      if (w_take && r_buf_data[DATA_W-1:DATA_W-4] == 4'd7) r_halted <= 1'b1;
    end
  end
  assign mem_req  = r_req;
  assign mem_addr = r_pc;
  assign ir       = r_ir;
  assign extra    = r_ir_loaded & (r_ir[DATA_W-1:DATA_W-4] < 4'd4);
  assign stall    = fetch & (~r_buf_valid | r_halted);
  assign halted   = r_halted;
  assign pc       = r_pc;
endmodule

// File: tb/tb_mu0_fetch_unit.sv
// tb_mu0_fetch_unit: random and directed checks of mu0_fetch_unit against a transaction-level model.
module tb_mu0_fetch_unit;
  logic        clk = 0, rst_n = 1;
  logic        fetch = 0, exec1 = 0, pipeline_enabled = 0, jump = 0, mem_grant = 0, mem_ack = 0;
  logic [11:0] jump_addr = 0;
  logic [15:0] mem_rdata = 0;
  logic        mem_req, extra, stall, halted;
  logic [11:0] mem_addr, pc;
  logic [15:0] ir;
  mu0_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .fetch(fetch), .exec1(exec1), .pipeline_enabled(pipeline_enabled),
    .jump(jump), .jump_addr(jump_addr), .mem_grant(mem_grant), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .ir(ir), .extra(extra), .stall(stall), .halted(halted), .pc(pc)
  );
  always #5 clk = ~clk;
  logic [15:0] mem [0:4095];
  logic [11:0] m_pc;
  logic [15:0] m_buf, m_ir;
  bit          m_bv, m_ld, m_busy, m_stale, m_halt, spur;
  int          lat, lat_cfg;
  int          total = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic m_reset();
    m_pc = 0; m_buf = 0; m_ir = 0;
    m_bv = 0; m_ld = 0; m_busy = 0; m_stale = 0; m_halt = 0; lat = 0;
  endtask
  task automatic check_all();
    chk("req", mem_req, m_busy);
    if (m_busy) chk("addr", mem_addr, m_pc);
    chk("ir", ir, m_ir);
    chk("extra", extra, m_ld && m_ir[15:12] < 4);
    chk("stall", stall, fetch && (!m_bv || m_halt));
    chk("halted", halted, m_halt);
    chk("pc", pc, m_pc);
  endtask
  // one clock edge of the fetch stage seen as transactions: take, ack, jump, new request
  task automatic model_update();
    bit acked, take, issue, jmp;
    acked = m_busy && mem_ack;
    take  = fetch && m_bv && !m_halt;
    jmp   = jump && exec1;
    issue = !m_busy && !m_bv && mem_grant && !m_halt && !m_stale && (pipeline_enabled || fetch);
    if (m_busy && lat > 0) lat--;
    if (take) begin
      m_ir = m_buf; m_ld = 1; m_bv = 0;
      if (m_buf[15:12] == 4'h7) m_halt = 1;
    end
    if (acked) begin
      m_busy = 0;
      if (!jmp && !m_stale) begin m_buf = mem_rdata; m_bv = 1; m_pc = m_pc + 12'd1; end
      m_stale = 0;
    end
    if (jmp) begin
      m_pc = jump_addr; m_bv = 0;
      if (m_busy) m_stale = 1;
    end
    if (issue) begin
      m_busy = 1;
      lat = lat_cfg < 0 ? int'($urandom_range(3)) : lat_cfg;
    end
  endtask
  task automatic step();
    mem_ack   = (m_busy && lat == 0) || spur;
    mem_rdata = (m_busy && lat == 0) ? mem[m_pc] : 16'($urandom);
    #1 check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
    spur = 0;
  endtask
  task automatic do_reset();
    rst_n = 0; fetch = 0; exec1 = 0; jump = 0; spur = 0; mem_ack = 0;
    m_reset();
    @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_ir", ir, 0);
    chk("rst_extra", extra, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_stall0", stall, 0);
    fetch = 1;
    #1 chk("rst_stall1", stall, 1);
    fetch = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    int n, sm, hc;
    bit stl;
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    // reset and first fetch
    do_reset();
    mem[0] = 16'h2005; lat_cfg = 0; mem_grant = 1; fetch = 1;
    step();
    chk("t1_req", mem_req, 1); chk("t1_addr", mem_addr, 0); chk("t1_stall", stall, 1);
    step(); step();
    chk("t1_ir", ir, 16'h2005); chk("t1_extra", extra, 1); chk("t1_pc", pc, 1);
    // pipelined prefetch
    do_reset();
    pipeline_enabled = 1; lat_cfg = 3; mem[0] = 16'h1000; mem[1] = 16'h2000; fetch = 1;
    for (n = 0; n < 20 && !m_bv; n++) step();
    step();
    fetch = 0; exec1 = 1;
    step();
    exec1 = 0;
    chk("t2_req", mem_req, 1); chk("t2_addr", mem_addr, 1);
    step();
    for (n = 0; n < 20 && !m_bv; n++) step();
    fetch = 1;
    #1 chk("t2_stall", stall, 0);
    step();
    chk("t2_ir", ir, 16'h2000);
    // jump while a request is outstanding
    do_reset();
    pipeline_enabled = 0; mem_grant = 0; lat_cfg = 5; mem[3] = 16'h3333; mem[12'h040] = 16'h0040;
    exec1 = 1; jump = 1; jump_addr = 12'h003;
    step();
    jump = 0; exec1 = 0; fetch = 1; mem_grant = 1;
    step();
    chk("t3_addr3", mem_addr, 12'h003); chk("t3_req", mem_req, 1);
    fetch = 0; exec1 = 1; jump = 1; jump_addr = 12'h040;
    step();
    jump = 0; exec1 = 0; fetch = 1;
    chk("t3_pcj", pc, 12'h040);
    for (n = 0; n < 20 && mem_req; n++) step();
    chk("t3_pc_kept", pc, 12'h040);
    for (n = 0; n < 20 && !mem_req; n++) step();
    chk("t3_addr40", mem_addr, 12'h040);
    for (n = 0; n < 20 && mem_req; n++) step();
    chk("t3_pc41", pc, 12'h041);
    step();
    chk("t3_ir", ir, 16'h0040);
    // PC wrap
    do_reset();
    mem_grant = 0; exec1 = 1; jump = 1; jump_addr = 12'hFFF; mem[12'hFFF] = 16'h5000; lat_cfg = 0;
    step();
    jump = 0; exec1 = 0; fetch = 1; mem_grant = 1;
    step();
    chk("t4_addr", mem_addr, 12'hFFF);
    step();
    chk("t4_pc", pc, 12'h000);
    for (n = 0; n < 20 && !mem_req; n++) step();
    chk("t4_req", mem_req, 1); chk("t4_addr0", mem_addr, 12'h000);
    // STP halts fetch
    do_reset();
    mem[0] = 16'h7000; lat_cfg = 0; mem_grant = 1; fetch = 1;
    step(); step(); step();
    chk("t5_halted", halted, 1);
    for (int i = 0; i < 30; i++) begin
      fetch = 1'($urandom_range(1)); pipeline_enabled = 1'($urandom_range(1));
      step();
      chk("t5_req", mem_req, 0);
      if (fetch) chk("t5_stall", stall, 1);
    end
    // reset in the middle of a request
    do_reset();
    pipeline_enabled = 0; lat_cfg = 5; fetch = 1; mem_grant = 1;
    step();
    chk("t6_req", mem_req, 1);
    do_reset();
    mem_grant = 0; fetch = 1; spur = 1;
    step();
    chk("t6_pc", pc, 0); chk("t6_noreq", mem_req, 0);
    mem_grant = 1;
    step();
    chk("t6_req2", mem_req, 1); chk("t6_addr", mem_addr, 0);
    // randomized FETCH/EXEC1/EXEC2 traffic
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i][15:12] == 4'h7 && $urandom_range(7) != 0) mem[i][15:12] = 4'h8;
    end
    do_reset();
    lat_cfg = -1; sm = 0; hc = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) pipeline_enabled = 1'($urandom_range(1));
      fetch = sm == 0; exec1 = sm == 1;
      jump = exec1 && $urandom_range(3) == 0;
      jump_addr = 12'($urandom);
      mem_grant = $urandom_range(4) != 0;
      spur = !m_busy && $urandom_range(19) == 0;
      stl = fetch && (!m_bv || m_halt);
      step();
      sm = sm == 0 ? (stl ? 0 : 1) : sm == 1 ? ((m_ld && m_ir[15:12] < 4 && !jump) ? 2 : 0) : 0;
      hc = m_halt ? hc + 1 : 0;
      if (hc > 20) begin do_reset(); sm = 0; hc = 0; end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
